// File: rtl/if_fetch_pkg.sv
// Shared CPU defines for the instruction-fetch stage: reset vector,
// bubble instruction, fetch FSM encodings and small address helpers.
package if_fetch_pkg;

  typedef logic [31:0] word_t;

  // First fetch address after reset.
  localparam word_t RESET_PC_DEF = 32'h0000_0000;

  // Bubble driven whenever no valid instruction is held (addi x0, x0, 0).
  localparam word_t NOP_INST_DEF = 32'h0000_0013;

  // Fetch FSM encodings, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Force an address onto a word boundary.
  function automatic word_t word_align(input word_t addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Sequential next fetch address; wraps modulo 2^32.
  function automatic word_t pc_incr(input word_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues one word request at a time to the
// instruction memory, holds the returned word for the decode stage and
// discards responses that belong to a path abandoned by a jump.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  word_t      pc;
  word_t      pc_nxt;
  word_t      inflight_addr;
  logic       kill;
  logic       slot_free;
  logic       grant;
  logic       resp;
  logic       capture;
  logic       consumed;

  // The output slot can take a new word if it is empty or is being consumed now.
  assign slot_free = !inst_valid_o || !hold_flag_i;

  // Requests are only raised in REQ so that at most one is ever outstanding.
  assign mem_req_o  = (state == ST_REQ) && slot_free;
  assign mem_addr_o = pc;

  assign grant    = mem_req_o && mem_gnt_i;
  // Read data only means anything while a request is outstanding.
  assign resp     = (state == ST_WAIT) && mem_rvalid_i;
  // A response is dropped if its request was killed or a jump lands on it.
  assign capture  = resp && !kill && !jump_flag_i;
  assign consumed = inst_valid_o && !hold_flag_i;

  // Next FSM state: one request, then wait for its single response.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ:  if (grant) state_nxt = ST_WAIT;
      ST_WAIT: if (mem_rvalid_i) state_nxt = ST_REQ;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next fetch address: advance on grant, a jump always wins.
  always_comb begin
    pc_nxt = pc;
    if (grant) begin
      pc_nxt = pc_incr(pc);
    end
    if (jump_flag_i) begin
      pc_nxt = word_align(jump_addr_i);
    end
  end

  // FSM state and fetch pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Kill flag marks the outstanding response as belonging to a dead path;
  // it is cleared by that response, including one coincident with a jump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill <= 1'b0;
    end else if (resp) begin
      kill <= 1'b0;
    end else if (jump_flag_i && ((state == ST_WAIT) || grant)) begin
      kill <= 1'b1;
    end
  end

  // Address of the outstanding request, tagged onto its returning word.
  always_ff @(posedge clk) begin
    if (grant) begin
      inflight_addr <= pc;
    end
  end

  // Output slot: capture new word, otherwise empty it on jump or consumption,
  // otherwise hold; an empty slot always presents the bubble instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_o       <= NOP_INST;
      inst_addr_o  <= 32'h0000_0000;
      inst_valid_o <= 1'b0;
    end else if (capture) begin
      inst_o       <= mem_rdata_i;
      inst_addr_o  <= inflight_addr;
      inst_valid_o <= 1'b1;
    end else if (jump_flag_i || consumed) begin
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a one-outstanding memory model and an
// in-order scoreboard of expected instruction addresses.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int grant_cyc = 0;
  int t0 = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  if_fetch dut (
    .clk(clk),
    .rst(rst),
    .jump_flag_i(jump_flag_i),
    .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .inst_o(inst_o),
    .inst_addr_o(inst_addr_o),
    .inst_valid_o(inst_valid_o)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'h0010_0093 ^ (a << 7);
  endfunction

  // Memory model: grant follows gnt_en, response after lat cycles; not reset.
  int          lat = 1;
  logic        gnt_en = 1'b1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;

  assign mem_gnt_i    = gnt_en;
  assign mem_rvalid_i = pend && (pend_cnt == 0);
  assign mem_rdata_i  = mem_rvalid_i ? data_of(pend_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (pend && pend_cnt == 0) pend <= 1'b0;
    else if (pend) pend_cnt <= pend_cnt - 1;
    if (mem_req_o && mem_gnt_i) begin
      pend      <= 1'b1;
      pend_addr <= mem_addr_o;
      pend_cnt  <= lat - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1ns later and score any newly presented word.
  task automatic step();
    logic pv, ph;
    logic [31:0] ea;
    pv = inst_valid_o;
    ph = hold_flag_i;
    @(posedge clk);
    #1;
    cyc++;
    if (!inst_valid_o) check("nop_when_invalid", inst_o, NOP);
    if (inst_valid_o && !(pv && ph)) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_inst: observed addr %h expected none", inst_addr_o);
      end
      if (exp_q.size() != 0) begin
        ea = exp_q.pop_front();
        check("inst_addr", inst_addr_o, ea);
        check("inst_data", inst_o, data_of(ea));
      end
    end
  endtask

  // Wait (this cycle included) for a granted request and check its address.
  task automatic wait_grant(input logic [31:0] exp, input string tag);
    int n;
    n = 0;
    #1;
    while (!(mem_req_o && mem_gnt_i) && n < 40) begin
      step();
      n++;
    end
    checks++;
    assert (mem_req_o && mem_gnt_i) else begin
      errors++;
      $error("FAIL %s_timeout: observed no grant expected grant at %h", tag, exp);
    end
    if (mem_req_o && mem_gnt_i) check(tag, mem_addr_o, exp);
    grant_cyc = cyc;
  endtask

  // Wait (this cycle included) until the given address is presented.
  task automatic wait_inst(input logic [31:0] a, input string tag);
    int n;
    n = 0;
    #1;
    while (!(inst_valid_o && inst_addr_o == a) && n < 40) begin
      step();
      n++;
    end
    checks++;
    assert (inst_valid_o && inst_addr_o == a) else begin
      errors++;
      $error("FAIL %s_timeout: observed valid=%b addr=%h expected addr %h", tag, inst_valid_o, inst_addr_o, a);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, {31'b0, inst_valid_o}, 32'd0);
    check({tag, "_inst"}, inst_o, NOP);
    check({tag, "_inst_addr"}, inst_addr_o, 32'h0);
    check({tag, "_req"}, {31'b0, mem_req_o}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr_o, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    jump_flag_i = 1'b0;
    jump_addr_i = 32'h0;
    hold_flag_i = 1'b0;
    step();
    step();
    check_reset_values("reset");

    // Streaming fetch, one word every two cycles.
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    rst = 1'b0;
    wait_grant(32'h0, "first_fetch_addr");
    t0 = grant_cyc;
    wait_inst(32'h0, "inst0");
    check("latency_inst0", 32'(cyc - t0), 32'd2);
    wait_inst(32'h4, "inst4");
    check("latency_inst4", 32'(cyc - t0), 32'd4);
    wait_inst(32'h8, "inst8");
    check("latency_inst8", 32'(cyc - t0), 32'd6);

    // Downstream stall holds the slot and blocks further requests.
    hold_flag_i = 1'b1;
    #1;
    check("hold_req_low", {31'b0, mem_req_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", {31'b0, inst_valid_o}, 32'd1);
      check("hold_addr", inst_addr_o, 32'h8);
      check("hold_inst", inst_o, data_of(32'h8));
      check("hold_req", {31'b0, mem_req_o}, 32'd0);
    end
    hold_flag_i = 1'b0;
    #1;
    check("release_req", {31'b0, mem_req_o}, 32'd1);
    check("release_addr", mem_addr_o, 32'hC);
    exp_q.push_back(32'hC);
    wait_inst(32'hC, "inst12");

    // Reset during WAIT; stale response arrives after release and is ignored.
    lat = 3;
    wait_grant(32'h10, "grant16");
    step();
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    step();
    rst = 1'b0;
    lat = 1;
    exp_q.push_back(32'h0);
    wait_grant(32'h0, "restart_addr");
    wait_inst(32'h0, "restart_inst0");

    // Jump while waiting on address 4: its response is killed.
    lat = 3;
    wait_grant(32'h4, "grant4");
    step();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0103;
    exp_q.push_back(32'h100);
    step();
    jump_flag_i = 1'b0;
    lat = 1;
    wait_grant(32'h100, "jump_wait_target");
    check("valid_low_after_jump", {31'b0, inst_valid_o}, 32'd0);
    wait_inst(32'h100, "inst100");

    // Jump coincident with grant.
    wait_grant(32'h104, "grant104");
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0200;
    exp_q.push_back(32'h200);
    step();
    jump_flag_i = 1'b0;
    wait_grant(32'h200, "jump_on_gnt_target");
    wait_inst(32'h200, "inst200");

    // Jump coincident with rvalid.
    wait_grant(32'h204, "grant204");
    step();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0300;
    exp_q.push_back(32'h300);
    step();
    jump_flag_i = 1'b0;
    wait_grant(32'h300, "jump_on_rvalid_target");
    wait_inst(32'h300, "inst300");

    // Top-of-memory fetch wraps to zero; unaligned jump target is aligned.
    wait_grant(32'h304, "grant304");
    step();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFF;
    exp_q.push_back(32'hFFFF_FFFC);
    step();
    jump_flag_i = 1'b0;
    wait_grant(32'hFFFF_FFFC, "high_addr");
    exp_q.push_back(32'h0);
    step();
    wait_grant(32'h0, "wrap_addr");

    // Jump in REQ without grant retargets the pending request.
    step();
    gnt_en = 1'b0;
    step();
    check("stalled_addr", mem_addr_o, 32'h4);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0400;
    exp_q.push_back(32'h400);
    step();
    jump_flag_i = 1'b0;
    check("jump_no_gnt_addr", mem_addr_o, 32'h400);
    check("jump_no_gnt_req", {31'b0, mem_req_o}, 32'd1);
    gnt_en = 1'b1;
    wait_grant(32'h400, "grant400");
    step();
    gnt_en = 1'b0;
    wait_inst(32'h400, "inst400");
    repeat (6) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, is the instruction word driven while no valid instruction is present.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 jump_flag_i  input  1  redirect request from the execute stage, one-cycle pulse.
REQ-006 jump_addr_i  input  32  redirect target.
REQ-007 hold_flag_i  input  1  downstream stall; the output instruction is not consumed while high.
REQ-008 mem_req_o  output  1  instruction-memory request.
REQ-009 mem_addr_o  output  32  request address, word aligned.
REQ-010 mem_gnt_i  input  1  memory accepts the request in this cycle.
REQ-011 mem_rvalid_i  input  1  read data valid.
REQ-012 mem_rdata_i  input  32  read data.
REQ-013 inst_o  output  32  fetched instruction, registered.
REQ-014 inst_addr_o  output  32  address of inst_o, registered.
REQ-015 inst_valid_o  output  1  inst_o is valid, registered.

Function
REQ-016 FSM states: IDLE, REQ, WAIT; reset state IDLE; IDLE -> REQ unconditionally after reset release.
REQ-017 Slot-free condition: !inst_valid_o, or inst_valid_o && !hold_flag_i (consumed at this edge).
REQ-018 REQ: mem_req_o = slot-free; mem_addr_o = pc; on mem_req_o && mem_gnt_i -> WAIT, inflight_addr <= pc, pc <= pc + 4 (32-bit wrap, 32'hFFFF_FFFC -> 32'h0).
REQ-019 WAIT: mem_req_o = 0; on mem_rvalid_i -> REQ; if kill flag clear, inst_o <= mem_rdata_i, inst_addr_o <= inflight_addr, inst_valid_o <= 1.
REQ-020 At most one outstanding memory request; mem_rvalid_i outside WAIT is ignored.
REQ-021 Consumption: inst_valid_o && !hold_flag_i at an edge clears inst_valid_o unless a new instruction is captured at that same edge.
REQ-022 While hold_flag_i is high and inst_valid_o is high, inst_o, inst_addr_o and inst_valid_o are held unchanged.
REQ-023 Jump: pc <= {jump_addr_i[31:2], 2'b00}; inst_valid_o <= 0; inst_o <= NOP_INST; jump overrides hold.
REQ-024 Jump while in WAIT, or in REQ coincident with mem_gnt_i: kill flag <= 1; the matching response is discarded, and the kill flag clears on that response.
REQ-025 Jump coincident with mem_rvalid_i in WAIT: the response is discarded and the next request uses the jump target.
REQ-026 Jump in REQ without grant: the next request uses the jump target; no kill.
REQ-027 Best-case latency: grant in cycle N, rvalid in N+1, inst_valid_o high in N+2; peak throughput one instruction per two cycles.
REQ-028 Whenever inst_valid_o is 0, inst_o = NOP_INST.

Reset
REQ-029 On rst high, asynchronously: state = IDLE, pc = RESET_PC, kill = 0, inst_o = NOP_INST, inst_addr_o = 0, inst_valid_o = 0, mem_req_o = 0, mem_addr_o = RESET_PC.
REQ-030 Reset asserted mid-transaction abandons the outstanding request; a response arriving after reset release while in IDLE or REQ is ignored.

Structure
REQ-031 RESET_PC default, NOP_INST, and the FSM state encodings reside in the shared CPU defines file.
REQ-032 Single module; no sub-module; pc, kill flag, and output registers are local sequential logic.

Verification
REQ-033 Reset release, gnt and rvalid always 1 with one-cycle latency, rdata = 32'h0010_0093 -> first mem_addr_o = 0; inst_valid_o rises with inst_addr_o = 0, then 4, 8 every two cycles.
REQ-034 hold_flag_i high for 5 cycles while inst_addr_o = 8 -> outputs stable, mem_req_o = 0; after release, next request address = 12.
REQ-035 Jump to 32'h0000_0103 while in WAIT for address 4 -> response for 4 discarded; next mem_addr_o = 32'h0000_0100; inst_valid_o stays 0 until its data arrives.
REQ-036 Jump in the same cycle as gnt, and separately as rvalid -> no instruction from the old path appears at the output.
REQ-037 rst pulsed during WAIT, stale rvalid two cycles later -> ignored; fetch restarts at RESET_PC.
REQ-038 pc = 32'hFFFF_FFFC fetched -> next mem_addr_o = 32'h0000_0000.
